// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection pipeline.
// PIX_W    : pixel width in bits
// WIN_TAPS : number of taps in a 3x3 neighbourhood
// window_t : 3x3 window, element k = tap p<k> (row-major, top-left first).
//            The Sobel stage uses this type too.
// state_t  : raster tracking state of the window generator
package edge_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;

  typedef logic [WIN_TAPS-1:0][PIX_W-1:0] window_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage.
// Ports:
//   clk   : write clock
//   we    : write enable
//   addr  : column address, shared by the read and write ports
//   wdata : pixel written at addr
//   rdata : combinational read at addr; during a write it returns the
//           value stored before this write
// Contents have no reset and are undefined until first written.
module line_buffer
  import edge_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = PIX_W,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-window stage ahead of the Sobel operator. Buffers the two previous
// rows and emits one 3x3 neighbourhood per interior pixel.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous reset, active HIGH despite the name
//   pix_valid  : pixel_in valid this cycle
//   pixel_in   : unsigned input pixel
//   sof        : start of frame, qualified by pix_valid, marks pixel (0,0)
//   win_valid  : one-cycle pulse, win_data/ctr_row/ctr_col valid
//   win_data   : 3x3 window, byte k = tap p<k>, row-major from top-left
//   ctr_row    : row of window centre
//   ctr_col    : column of window centre
//   frame_done : pulse after the last pixel of a frame is accepted
//   frame_err  : pulse when sof is accepted mid-frame
//   dbg_state  : FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: pix_valid is a pure valid with no ready. A pixel is consumed on
// every rising edge where pix_valid=1 and either the FSM is ACTIVE or sof=1;
// the source may insert gaps but can never be stalled.
module sobel_window_gen
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int ROW_W = $clog2(IMG_HEIGHT),
  localparam int COL_W = $clog2(IMG_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_valid,
  input  logic [PIX_W-1:0]          pixel_in,
  input  logic                      sof,
  output logic                      win_valid,
  output logic [PIX_W*WIN_TAPS-1:0] win_data,
  output logic [ROW_W-1:0]          ctr_row,
  output logic [COL_W-1:0]          ctr_col,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      dbg_state
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic             accept, sof_acc, last_pix, emit, err_now;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // Stage 1: window shifter plus the per-accept event flags.
  window_t          win_q;
  logic             emit_q, done_q, err_q;
  logic [ROW_W-1:0] crow_q;
  logic [COL_W-1:0] ccol_q;

  // A sof-qualified pixel is always (0,0), so the counters are bypassed
  // for it rather than waiting a cycle for them to clear.
  always_comb begin
    sof_acc  = pix_valid && sof;
    accept   = pix_valid && (sof || (state_q == ACTIVE));
    err_now  = sof_acc && (state_q == ACTIVE);
    cur_row  = sof_acc ? '0 : row_q;
    cur_col  = sof_acc ? '0 : col_q;
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    // Rows 0/1 and columns 0/1 have no full neighbourhood yet; this also
    // keeps stale line-buffer rows from an aborted frame off the output.
    emit     = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accept) begin
      state_d = last_pix ? IDLE : ACTIVE;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // lb0 = previous row, lb1 = the row before it. On each accept the column
  // ripples up: lb1 takes lb0's old value, lb0 takes the new pixel.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (pixel_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_q  <= '0;
      emit_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      crow_q <= '0;
      ccol_q <= '0;
    end else begin
      emit_q <= emit;
      done_q <= accept && last_pix;
      err_q  <= err_now;
      if (accept) begin
        // Shift every row one tap left; the new column enters on the right.
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= pixel_in;
      end
      if (emit) begin
        crow_q <= cur_row - ROW_W'(1);
        ccol_q <= cur_col - COL_W'(1);
      end
    end
  end

  // Stage 2: output registers; data and centre hold between windows.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_valid  <= 1'b0;
      win_data   <= '0;
      ctr_row    <= '0;
      ctr_col    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      win_valid  <= emit_q;
      frame_done <= done_q;
      frame_err  <= err_q;
      if (emit_q) begin
        win_data <= win_q;
        ctr_row  <= crow_q;
        ctr_col  <= ccol_q;
      end
    end
  end

  assign dbg_state = (state_q == ACTIVE);

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  // Observation word: {valid, done, err, data[71:0], row, col}
  localparam int OW = 3 + 72 + RW + CW;
  localparam int B_VALID = OW - 1;
  localparam int B_DONE  = OW - 2;
  localparam int B_ERR   = OW - 3;

  localparam logic [71:0] FIRST_WIN = {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LAST_WIN  = {8'd34, 8'd33, 8'd32, 8'd24, 8'd23, 8'd22, 8'd14, 8'd13, 8'd12};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pix_valid = 1'b0;
  logic sof = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic win_valid;
  logic [71:0] win_data;
  logic [RW-1:0] ctr_row;
  logic [CW-1:0] ctr_col;
  logic frame_done, frame_err, dbg_state;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pixel_in   (pixel_in),
    .sof        (sof),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .ctr_row    (ctr_row),
    .ctr_col    (ctr_col),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] obs_q[$];
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: the frame as a 2-D image, filled as pixels are accepted.
  bit m_active = 1'b0;
  int m_row = 0;
  int m_col = 0;
  int img[H][W];

  // ---------------- driver ----------------
  // One clock: sample outputs (masked where the spec leaves them don't-care),
  // drive the inputs for the next edge, and record what that edge must yield
  // two samples later.
  task automatic drive_cycle(input bit v, input bit s, input logic [7:0] p);
    logic [OW-1:0] o;
    logic [OW-1:0] e;
    logic [71:0] d;
    @(negedge clk);
    if (win_valid) o = {1'b1, frame_done, frame_err, win_data, ctr_row, ctr_col};
    else           o = {1'b0, frame_done, frame_err, {(72 + RW + CW){1'b0}}};
    obs_q.push_back(o);
    pix_valid = v;
    sof       = s;
    pixel_in  = p;
    e = '0;
    d = '0;
    if (v && (m_active || s)) begin
      if (s) begin
        e[B_ERR] = m_active;
        m_active = 1'b1;
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = int'(p);
      if (m_row >= 2 && m_col >= 2) begin
        for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'(img[m_row - 2 + k / 3][m_col - 2 + k % 3]);
        e[B_VALID] = 1'b1;
        e[B_ERR - 1 -: 72] = d;
        e[RW + CW - 1 : CW] = RW'(m_row - 1);
        e[CW - 1 : 0] = CW'(m_col - 1);
      end
      if (m_row == H - 1 && m_col == W - 1) begin
        e[B_DONE] = 1'b1;
        m_active = 1'b0;
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 8'd0);
  endtask

  // mode 0: continuous, 1: valid toggles 1/0, 2: random gaps and random pixels
  task automatic send_pixels(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      logic [7:0] p;
      r = i / W;
      c = i % W;
      p = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'(10 * r + c);
      drive_cycle(1'b1, i == 0, p);
      if (mode == 1) drive_cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      if (mode == 2) begin
        repeat ($urandom_range(0, 2))
          drive_cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end
  endtask

  // Drop the expectations already matched against observations; the
  // remainder are still in flight in the DUT pipeline.
  task automatic retire();
    logic [OW-1:0] dummy;
    int n;
    n = obs_q.size();
    for (int i = 0; i < n; i++) dummy = exp_q.pop_front();
    obs_q.delete();
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][b]) n++;
    return n;
  endfunction

  function automatic int nth_valid(input int n);
    int seen = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][B_VALID]) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({win_valid, frame_done, frame_err, dbg_state} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 0000", {win_valid, frame_done, frame_err, dbg_state});
    end
    n_cmp++;
    if ({win_data, ctr_row, ctr_col} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, expected 0", {win_data, ctr_row, ctr_col});
    end
    rst_n = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic test_full_frame();
    int idx;
    send_pixels(0, W * H);
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_frame sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_VALID) != 6) begin
      n_fail++;
      $display("FAIL full_frame_count: got %0d, expected 6", count_bit(B_VALID));
    end
    idx = nth_valid(0);
    n_cmp++;
    if (idx < 0 || obs_q[idx] !== {3'b100, FIRST_WIN, RW'(1), CW'(1)}) begin
      n_fail++;
      $display("FAIL full_frame_first: idx %0d got %h, expected %h", idx, (idx < 0) ? '0 : obs_q[idx], {3'b100, FIRST_WIN, RW'(1), CW'(1)});
    end
    idx = nth_valid(5);
    n_cmp++;
    if (idx < 0 || obs_q[idx] !== {3'b110, LAST_WIN, RW'(2), CW'(3)}) begin
      n_fail++;
      $display("FAIL full_frame_last: idx %0d got %h, expected %h", idx, (idx < 0) ? '0 : obs_q[idx], {3'b110, LAST_WIN, RW'(2), CW'(3)});
    end
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frame_idle: got state %b, expected 0", dbg_state);
    end
    retire();
  endtask

  task automatic test_toggle();
    int idx;
    send_pixels(1, W * H);
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL toggle sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_VALID) != 6) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d, expected 6", count_bit(B_VALID));
    end
    idx = nth_valid(0);
    n_cmp++;
    if (idx < 0 || obs_q[idx][B_ERR - 1 -: 72] !== FIRST_WIN) begin
      n_fail++;
      $display("FAIL toggle_first: idx %0d, expected %h", idx, FIRST_WIN);
    end
    retire();
  endtask

  task automatic test_pre_sof();
    repeat (7) drive_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    send_pixels(0, W * H);
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pre_sof sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_VALID) != 6) begin
      n_fail++;
      $display("FAIL pre_sof_count: got %0d, expected 6", count_bit(B_VALID));
    end
    idx_check_first: begin
      int idx;
      idx = nth_valid(0);
      n_cmp++;
      if (idx < 0 || obs_q[idx] !== {3'b100, FIRST_WIN, RW'(1), CW'(1)}) begin
        n_fail++;
        $display("FAIL pre_sof_first: idx %0d, expected %h", idx, {3'b100, FIRST_WIN, RW'(1), CW'(1)});
      end
    end
    retire();
  endtask

  task automatic test_sof_abort();
    int idx;
    int eidx;
    send_pixels(0, 2 * W + 1);   // rows 0,1 and pixel (2,0)
    send_pixels(0, W * H);       // sof lands where (2,1) would have been
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sof_abort sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_ERR) != 1) begin
      n_fail++;
      $display("FAIL sof_abort_err: got %0d pulses, expected 1", count_bit(B_ERR));
    end
    n_cmp++;
    if (count_bit(B_VALID) != 6) begin
      n_fail++;
      $display("FAIL sof_abort_count: got %0d, expected 6", count_bit(B_VALID));
    end
    idx = nth_valid(0);
    eidx = -1;
    foreach (obs_q[i]) if (obs_q[i][B_ERR] && eidx < 0) eidx = i;
    // New frame's (2,2) is 2*W+2 accepts after the sof pixel.
    n_cmp++;
    if (idx < 0 || eidx < 0 || idx - eidx != 2 * W + 2 || obs_q[idx][B_ERR - 1 -: 72] !== FIRST_WIN) begin
      n_fail++;
      $display("FAIL sof_abort_first: window at %0d, err at %0d, expected gap %0d and data %h", idx, eidx, 2 * W + 2, FIRST_WIN);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    send_pixels(0, 2 * W + 3);   // up to (2,2), whose window is still in flight
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_pre sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pix_valid = 1'b0;
    sof = 1'b0;
    #1;
    n_cmp++;
    if ({win_valid, frame_done, frame_err, dbg_state, win_data, ctr_row, ctr_col} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, expected 0", {win_valid, frame_done, frame_err, dbg_state, win_data, ctr_row, ctr_col});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({win_valid, frame_done, frame_err, dbg_state} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got %b, expected 0000", {win_valid, frame_done, frame_err, dbg_state});
    end
    rst_n = 1'b0;
    m_active = 1'b0;
    m_row = 0;
    m_col = 0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    send_pixels(0, W * H);
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_frame sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_VALID) != 6 || count_bit(B_DONE) != 1) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d windows %0d done, expected 6 and 1", count_bit(B_VALID), count_bit(B_DONE));
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int idx;
    send_pixels(0, W * H);
    send_pixels(0, W * H);
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_VALID) != 12 || count_bit(B_DONE) != 2 || count_bit(B_ERR) != 0) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d win %0d done %0d err, expected 12 2 0", count_bit(B_VALID), count_bit(B_DONE), count_bit(B_ERR));
    end
    idx = nth_valid(6);
    n_cmp++;
    if (idx < 0 || obs_q[idx] !== {3'b100, FIRST_WIN, RW'(1), CW'(1)}) begin
      n_fail++;
      $display("FAIL back_to_back_second_first: idx %0d, expected %h", idx, {3'b100, FIRST_WIN, RW'(1), CW'(1)});
    end
    retire();
  endtask

  task automatic test_random();
    repeat (3) send_pixels(2, W * H);
    idle(3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random sample %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(B_VALID) != 18) begin
      n_fail++;
      $display("FAIL random_count: got %0d, expected 18", count_bit(B_VALID));
    end
    retire();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full_frame();
    test_toggle();
    test_pre_sof();
    test_sof_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window stage that sits directly upstream of the Sobel operator. It accepts a row-major 8-bit pixel stream, buffers the two previous image rows, and emits one complete 3x3 neighbourhood per interior pixel. Each window arrives in the coefficient order the Sobel stage expects, so gradients are computed on true spatial neighbours rather than on a 1-D shift history.

## Interface
- IMG_WIDTH, 640, pixels per row (≥3)
- IMG_HEIGHT, 480, rows per frame (≥3)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous reset, active-high (asserted = 1); port name kept per codebase convention
- pix_valid  in  1  pixel_in valid this cycle; gaps allowed
- pixel_in  in  8  input pixel, unsigned
- sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0)
- win_valid  out  1  win_data/ctr_row/ctr_col valid; single-cycle pulse per window
- win_data  out  72  3x3 window; byte k = win_data[8k+7:8k]
- ctr_row  out  $clog2(IMG_HEIGHT)  row of window centre
- ctr_col  out  $clog2(IMG_WIDTH)  column of window centre
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
- frame_err  out  1  one-cycle pulse when sof arrives mid-frame

## Operation
- **Accept:** a pixel is accepted on any edge with pix_valid=1 in state ACTIVE, or with pix_valid=1 and sof=1 in any state. There is no backpressure.
- **FSM:**
  - IDLE: pixels without sof are ignored. An accepted sof moves to ACTIVE with row=0, col=0.
  - ACTIVE: each accept advances col. At col=IMG_WIDTH-1, col wraps to 0 and row increments. Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) pulses frame_done and returns to IDLE.
  - sof while ACTIVE: pulses frame_err, aborts the current frame, and treats that pixel as (0,0) of a new frame. Line-buffer contents are not cleared; row gating below prevents stale output.
- **Line buffers:** lb0 holds the previous row and lb1 the row before it, each IMG_WIDTH x 8. On accept at column c:
  - read lb1[c] and lb0[c] combinationally;
  - write lb1[c] ← old lb0[c] and lb0[c] ← pixel_in.
- **Window registers:** 3 columns x 3 rows. On accept, shift left and load the right column with {top=lb1[c], mid=lb0[c], bot=pixel_in}. Hold when there is no accept.
- **Byte order:** p0..p8 run row-major, top-left to bottom-right.
  - p0=(r-1,c-1), p1=(r-1,c), p2=(r-1,c+1)
  - p3..p5 = centre row
  - p6..p8 = bottom row
- **Emission:** a window is emitted when the accepted pixel has row≥2 and col≥2. The centre is (row-1, col-1). Border pixels produce no window.
- **Window count:** (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
- **Reset values:** all outputs are 0. FSM=IDLE and counters=0. Line-buffer contents are don't-care.
- Reset mid-frame discards the frame, with no frame_done or frame_err pulse.

## Timing
- Latency is exactly 1 clock: the window completed by an accept at edge N is presented with win_valid=1 after edge N+1.
- Throughput is one window per clock at a sustained pix_valid=1.
- Outputs hold their last value while win_valid=0.
- frame_done and frame_err are registered and appear on the same cycle as any win_valid caused by the same accept.

## Structure
- Shared package `edge_pkg` holds:
  - PIX_W=8;
  - WIN_TAPS=9;
  - a window type (array of 9 pixels);
  - FSM state enum {IDLE, ACTIVE}.
  The Sobel stage reuses the window type.
- Sub-module `line_buffer`: parameterized depth, one write port and one combinational read port at the same address. Read returns the pre-write value. Instantiate it twice.
- Top level owns the counters, FSM, window shifter and output registers.

## Test plan
All scenarios use IMG_WIDTH=5, IMG_HEIGHT=4, and pixel value = 10*row+col.
- **Full frame, continuous pix_valid:** exactly 6 win_valid pulses. The first has ctr=(1,1) and bytes {0,1,2,10,11,12,20,21,22}. The last has ctr=(2,3) and bytes {12,13,14,22,23,24,32,33,34}. frame_done pulses with the last window.
- **Same frame with pix_valid toggling 1/0:** identical window contents and order. Each window appears 1 cycle after its completing accept.
- **Pixels before any sof:** ignored, with no win_valid. The following sof frame behaves as in the first scenario.
- **sof reasserted at pixel (2,1):**
  - frame_err pulses;
  - no window appears until the new frame's pixel (2,2);
  - the new frame yields 6 correct windows.
- **rst_n pulsed high mid-frame:** all outputs read 0 and the FSM is IDLE. There is no frame_done. A fresh frame yields 6 correct windows.
- **Two back-to-back frames, sof on the cycle right after frame_done's accept:** 12 windows total, and the second frame's first window again reads {0,1,2,10,11,12,20,21,22}.
